// File: rtl/jk_input_conditioner_if.sv
// Signal bundle between the raw J/K pins and the conditioned J/K levels and strobes.
// The conditioner takes the slave view; whoever drives the raw pins takes the master view.
interface jk_input_conditioner_if;
    logic J_raw;
    logic K_raw;
    logic J;
    logic K;
    logic J_rise;
    logic K_rise;
    logic change;

    modport master (
        output J_raw, K_raw,
        input  J, K, J_rise, K_rise, change
    );

    modport slave (
        input  J_raw, K_raw,
        output J, K, J_rise, K_rise, change
    );
endinterface

// File: rtl/jk_input_conditioner.sv
// Synchronises and debounces the raw J/K switch inputs. It presents settled levels plus
// one-cycle strobes for each accepted change. Channel 0 is J and channel 1 is K.
module jk_input_conditioner #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                    clk,
    input  logic                    Clear_n,
    jk_input_conditioner_if.slave   bus
);

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] update;
    logic       change_q;

    assign raw = {bus.K_raw, bus.J_raw};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic            s1_q;
        logic            s2_q;
        logic            out_q;
        logic            out_d;
        logic            rise_q;
        logic            upd;
        db_state_e       state_q;
        db_state_e       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values; the synchroniser chain depends on this to stay two deep.
        always_ff @(posedge clk or negedge Clear_n) begin
            if (!Clear_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= STABLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                s1_q    <= raw[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= upd & s2_q;
            end
        end

        // NOTE: every combinational output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            upd     = 1'b0;
            case (state_q)
                STABLE: begin
                    if (s2_q != out_q) begin
                        if (DB_CYCLES == 1) begin
                            out_d = s2_q;
                            upd   = 1'b1;
                        end else begin
                            state_d = COUNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                COUNT: begin
                    // A bounce back to the current level throws away the partial count.
                    if (s2_q == out_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        out_d   = s2_q;
                        upd     = 1'b1;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        assign level[i]  = out_q;
        assign rise[i]   = rise_q;
        assign update[i] = upd;
    end

    // Simultaneous updates on both channels collapse into one pulse.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            change_q <= 1'b0;
        end else begin
            change_q <= |update;
        end
    end

    assign bus.J      = level[0];
    assign bus.K      = level[1];
    assign bus.J_rise = rise[0];
    assign bus.K_rise = rise[1];
    assign bus.change = change_q;

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner with DB_CYCLES=4. Observed outputs are packed
// as {J, K, J_rise, K_rise, change} and sampled 1 time unit after each rising edge.
module tb_jk_input_conditioner;

    logic clk;
    logic Clear_n;
    int   checks;
    int   errors;

    jk_input_conditioner_if ifc ();

    jk_input_conditioner #(
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .Clear_n (Clear_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {ifc.J, ifc.K, ifc.J_rise, ifc.K_rise, ifc.change};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (J K Jr Kr ch)", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Clear_n     = 1'b0;
        ifc.J_raw   = 1'b0;
        ifc.K_raw   = 1'b0;
        #12;
        check("reset_state", 5'b00000);
        @(posedge clk);
        #1;
        Clear_n = 1'b1;
        tick(3);
        check("idle_after_release", 5'b00000);

        // Clean J rise: raw changes before edge E; output expected at E+5.
        ifc.J_raw = 1'b1;
        tick(4);
        check("j_rise_e3", 5'b00000);
        tick(1);
        check("j_rise_e4", 5'b00000);
        tick(1);
        check("j_rise_e5", 5'b10101);
        tick(1);
        check("j_rise_e6", 5'b10000);

        // K bounce: high for only 3 sampled edges, never accepted.
        ifc.K_raw = 1'b1;
        tick(3);
        ifc.K_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("k_bounce_%0d", i), 5'b10000);
            tick(1);
        end

        // K held high: accepted 5 edges after the final 0->1.
        ifc.K_raw = 1'b1;
        tick(4);
        check("k_hold_e3", 5'b10000);
        tick(1);
        check("k_hold_e4", 5'b10000);
        tick(1);
        check("k_hold_e5", 5'b11011);
        tick(1);
        check("k_hold_e6", 5'b11000);

        // J fall: change strobe without J_rise.
        ifc.J_raw = 1'b0;
        tick(4);
        check("j_fall_e3", 5'b11000);
        tick(1);
        check("j_fall_e4", 5'b11000);
        tick(1);
        check("j_fall_e5", 5'b01001);
        tick(1);
        check("j_fall_e6", 5'b01000);

        // K fall back to idle.
        ifc.K_raw = 1'b0;
        tick(5);
        check("k_fall_e4", 5'b01000);
        tick(1);
        check("k_fall_e5", 5'b00001);
        tick(1);
        check("k_fall_e6", 5'b00000);

        // Simultaneous rise of both channels: single change pulse.
        ifc.J_raw = 1'b1;
        ifc.K_raw = 1'b1;
        tick(5);
        check("sim_e4", 5'b00000);
        tick(1);
        check("sim_e5", 5'b11111);
        tick(1);
        check("sim_e6", 5'b11000);
        tick(1);
        check("sim_e7", 5'b11000);

        // Mid-cycle asynchronous reset with both raw inputs high.
        #3;
        Clear_n = 1'b0;
        #1;
        check("async_reset_immediate", 5'b00000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("reset_held_%0d", i), 5'b00000);
        end

        // Release with raw low, then reset in the middle of a J qualification.
        ifc.J_raw = 1'b0;
        ifc.K_raw = 1'b0;
        Clear_n   = 1'b1;
        tick(3);
        check("idle_before_midcount", 5'b00000);
        ifc.J_raw = 1'b1;
        tick(4);
        check("midcount_e3", 5'b00000);
        Clear_n = 1'b0;
        #4;
        check("midcount_in_reset", 5'b00000);
        @(posedge clk);
        #1;
        Clear_n = 1'b1;
        // Next edge is the first after release; s1 recaptures J there.
        tick(5);
        check("recapture_e4", 5'b00000);
        tick(1);
        check("recapture_e5", 5'b10101);
        tick(1);
        check("recapture_e6", 5'b10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_input_conditioner.md
# jk_input_conditioner

Input conditioning stage that sits directly upstream of the board-level JK flip-flop stage. It takes the raw J and K switch/button signals from the FPGA pins, synchronises each to `clk`, debounces each with a consecutive-sample counter, and presents clean, glitch-free J and K levels. It also emits one-cycle strobes marking each accepted change. The downstream flip-flop's 1 Hz clock domain then sees only settled inputs.

## Interface

**Parameters**
- `DB_CYCLES`, default 1000000: consecutive `clk` samples a new level must persist before it is accepted; legal range ≥ 1.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES-1.

**Ports**
- `clk` input 1: single system clock (board oscillator); all logic is on its rising edge.
- `Clear_n` input 1: asynchronous, active-low reset.
- `J_raw` input 1: raw J switch, asynchronous to `clk`, may bounce.
- `K_raw` input 1: raw K switch, asynchronous to `clk`, may bounce.
- `J` output 1: debounced J level; feeds the JK stage J input.
- `K` output 1: debounced K level; feeds the JK stage K input.
- `J_rise` output 1: one-cycle pulse in the cycle `J` first reads 1 after being 0.
- `K_rise` output 1: one-cycle pulse in the cycle `K` first reads 1 after being 0.
- `change` output 1: one-cycle pulse in any cycle where `J` or `K` took a new value.

## Operation

- **Reset:** `Clear_n`=0 forces all flops to 0 immediately, regardless of `clk`. This covers the synchronisers, counters, `J`, `K`, `J_rise`, `K_rise` and `change`. The reset output J=K=0 is the hold condition for the JK stage.
- **Synchroniser:** each channel has a 2-flop synchroniser, `s1` ← raw and `s2` ← `s1`. Only `s2` is used downstream.
- **Per-channel state machine,** with J and K identical and fully independent:
  - **STABLE** (cnt = 0, `s2` == out): if `s2` != out, go to COUNT with cnt ← 1. If DB_CYCLES = 1, instead update out immediately and stay in STABLE.
  - **COUNT** (`s2` != out), at each edge:
    - If `s2` == out (bounce back), cnt ← 0 and go to STABLE; out is unchanged.
    - Else if cnt == DB_CYCLES-1, out ← `s2`, cnt ← 0, go to STABLE.
    - Else cnt ← cnt+1.
- **Strobes:** all strobes are registered and updated on the same edge as the output update, so each is high for exactly the one cycle in which the new level first appears.
  - `J_rise`/`K_rise` assert only on a 0→1 update.
  - `change` asserts on any update of either channel. Simultaneous updates of both channels produce a single one-cycle `change` pulse.
  - Strobes are 0 in every other cycle.
- **Counter:** `CNT_W`-bit unsigned. It never exceeds DB_CYCLES-1 and never wraps.
- **Raw level in COUNT:** a raw level that differs from out for fewer than DB_CYCLES consecutive sampled edges is discarded entirely. A raw level that flips again while in COUNT restarts the qualification.

## Timing

- If raw changes with setup before edge E: `s1` takes it at E, `s2` at E+1, and the first mismatch is seen at E+2.
- Accepted change appears on the output at edge **E+1+DB_CYCLES**. The strobe is valid in the same cycle.
- Minimum spacing between two accepted changes on one channel is DB_CYCLES cycles.
- Reset assertion is asynchronous. Deassertion must be synchronous to `clk` at the board level.
  - After `Clear_n` rises, a raw input already at 1 is accepted at edge 2+DB_CYCLES counted from the first edge after release, i.e. 1+DB_CYCLES edges after the edge on which `s1` captures it.
- Reset mid-COUNT discards the partial count; the output stays 0.
- No combinational path from any input to any output.

## Test plan

Run with DB_CYCLES=4, CNT_W=3.

1. **Reset:** assert `Clear_n`=0 mid-cycle with J_raw=K_raw=1 → all outputs 0 immediately, and they stay 0 while reset is held.
2. **Clean rise:** J_raw 0→1 before edge E, then held → `J`=1 and `J_rise`=1 at edge E+5; `change`=1 in the same cycle. `J_rise` falls at E+6 while `J` stays 1. `K` and `K_rise` stay 0.
3. **Bounce rejection:** K_raw pulses high for 3 cycles, then returns to 0 → `K`, `K_rise` and `change` stay 0 throughout. Then K_raw held high for 4+ cycles → `K` rises 5 edges after the final 0→1 transition.
4. **Simultaneous:** J_raw and K_raw rise in the same cycle → `J` and `K` update on the same edge; `J_rise`=`K_rise`=1; `change` is a single one-cycle pulse.
5. **Fall:** with `J`=1, drop J_raw to 0 → `J`=0 at E+5 with `change`=1 and `J_rise`=0.
6. **Reset mid-count:** J_raw rises; pulse `Clear_n` low at E+3, release, keep J_raw=1 → `J` stays 0 until 5 edges after `s1` recaptures the 1, then rises with `J_rise`.
